// File: rtl/fp_sp_pkg.sv
// Shared IEEE-754 single-precision field definitions, used by the int-to-float
// converter and the SP adder.
package fp_sp_pkg;

    localparam int FP_SP_BIAS   = 127;
    localparam int FP_SP_EXP_W  = 8;
    localparam int FP_SP_FRAC_W = 23;

    // Largest biased exponent a 32-bit integer can produce: 2^31.
    localparam int FP_I2F_EXP_MAX = FP_SP_BIAS + 31;

    typedef struct packed {
        logic                    sign;
        logic [FP_SP_EXP_W-1:0]  exp;
        logic [FP_SP_FRAC_W-1:0] frac;
    } fp_sp_t;

    function automatic fp_sp_t fp_sp_pack(input logic                    sign,
                                          input logic [FP_SP_EXP_W-1:0]  exp,
                                          input logic [FP_SP_FRAC_W-1:0] frac);
        fp_sp_t r;
        r.sign = sign;
        r.exp  = exp;
        r.frac = frac;
        return r;
    endfunction

endpackage

// File: rtl/fp_lzc32.sv
// 32-bit leading-zero counter, purely combinational. o_CNT is 0 when the
// input is zero; o_ZERO flags that case.
module fp_lzc32 (
    input  logic [31:0] i_DATA,
    output logic [4:0]  o_CNT,
    output logic        o_ZERO
);

    logic found;

    always_comb begin
        o_CNT = '0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && i_DATA[i]) begin
                o_CNT = 5'(31 - i);
                found = 1'b1;
            end
        end
    end

    assign o_ZERO = ~|i_DATA;

endmodule

// File: rtl/fp_int2fp_sp.sv
// Signed 32-bit integer to IEEE-754 single converter, 3-stage pipeline.
// Define FP_I2F_RNE_EN for round-to-nearest-even; otherwise truncates.
module fp_int2fp_sp
    import fp_sp_pkg::*;
(
    input  logic        i_CLK,
    input  logic        i_RST_N,
    input  logic        i_VALID,
    output logic        o_READY,
    input  logic [31:0] i_INT,
    output logic        o_VALID,
    input  logic        i_READY,
    output logic [31:0] o_RES
);

    // Handshake: a word moves in when i_VALID & o_READY and out when
    // o_VALID & i_READY. The whole pipe advances together; o_READY low freezes
    // every stage, so o_RES is stable while o_VALID=1 and i_READY=0.
    logic adv;
    assign o_READY = ~o_VALID | i_READY;
    assign adv     = o_READY;

    // Stage 1: sign / magnitude
    logic        v1;
    logic        sign1;
    logic [31:0] mag1;

    // Stage 2: normalize
    logic        v2;
    logic        sign2;
    logic        zero2;
    logic [31:0] mant2;
    logic [7:0]  exp2;

    logic [4:0]  lzc;
    logic        lz_zero;
    logic [31:0] shifted;

    fp_lzc32 u_lzc (
        .i_DATA (mag1),
        .o_CNT  (lzc),
        .o_ZERO (lz_zero)
    );

    assign shifted = mag1 << lzc;

    // Stage 3: round / pack (combinational part)
    logic [22:0] frac_t;
    logic        inc;
    logic [23:0] frac_sum;
    logic [7:0]  exp_r;
    fp_sp_t      res_w;

    assign frac_t = mant2[30:8];

`ifdef FP_I2F_RNE_EN
    logic guard;
    logic sticky;
    logic unused_bits;

    assign guard       = mant2[7];
    assign sticky      = |mant2[6:0];
    assign inc         = guard & (sticky | frac_t[0]);
    assign unused_bits = mant2[31];
`else
    logic unused_bits;

    assign inc         = 1'b0;
    assign unused_bits = ^{mant2[31], mant2[7:0]};
`endif

    // A carry out of the fraction lands exactly on the next power of two.
    assign frac_sum = {1'b0, frac_t} + {23'b0, inc};
    assign exp_r    = exp2 + {7'b0, frac_sum[23]};

    always_comb begin
        res_w = fp_sp_pack(sign2, exp_r, frac_sum[22:0]);
        if (zero2) begin
            res_w = '0;
        end
    end

    // Control and output register: reset clears every valid bit and o_RES.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            o_VALID <= 1'b0;
            o_RES   <= '0;
        end else if (adv) begin
            v1      <= i_VALID;
            v2      <= v1;
            o_VALID <= v2;
            if (v2) begin
                o_RES <= res_w;
            end
        end
    end

    // Datapath registers carry no reset; their valid bits qualify them.
    always_ff @(posedge i_CLK) begin
        if (adv) begin
            sign1 <= i_INT[31];
            mag1  <= i_INT[31] ? (~i_INT + 32'd1) : i_INT;
            sign2 <= sign1;
            zero2 <= lz_zero;
            mant2 <= shifted;
            exp2  <= 8'(FP_I2F_EXP_MAX) - {3'b0, lzc};
        end
    end

endmodule

// File: tb/tb_fp_int2fp_sp.sv
// Self-checking bench for fp_int2fp_sp: directed literal cases, stall, mid-run
// reset and a randomized stream scored against an arithmetic reference model.
module tb_fp_int2fp_sp;

    logic        i_CLK = 1'b0;
    logic        i_RST_N;
    logic        i_VALID;
    logic        o_READY;
    logic [31:0] i_INT;
    logic        o_VALID;
    logic        i_READY;
    logic [31:0] o_RES;

    fp_int2fp_sp dut (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .i_VALID (i_VALID),
        .o_READY (o_READY),
        .i_INT   (i_INT),
        .o_VALID (o_VALID),
        .i_READY (i_READY),
        .o_RES   (o_RES)
    );

    // ---------------- clock / reset ----------------
    always #5 i_CLK = ~i_CLK;

    int cyc = 0;
    always @(posedge i_CLK) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] out_val[$];
    int          out_cyc[$];
    logic        hold_v = 1'b0;
    logic [31:0] hold_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, req);
        end
    endtask

    // Reference: locate the top set bit arithmetically, scale to 24 bits,
    // then round the discarded remainder against one half.
    function automatic logic [31:0] model_i2f(input logic [31:0] x);
        logic [63:0] m;
        logic [63:0] q;
        int          e;
        logic        s;
        s = x[31];
        m = s ? (64'h1_0000_0000 - {32'b0, x}) : {32'b0, x};
        if (m == 64'd0) return 32'h0;
        e = 0;
        while ((m >> (e + 1)) != 64'd0) e++;
        if (e > 23) begin
            q = m >> (e - 23);
`ifdef FP_I2F_RNE_EN
            begin
                logic [63:0] r;
                logic [63:0] half;
                r    = m - (q << (e - 23));
                half = 64'd1 << (e - 24);
                if (r > half || (r == half && q[0])) q = q + 64'd1;
                if (q == (64'd1 << 24)) begin
                    q = q >> 1;
                    e++;
                end
            end
`endif
        end else begin
            q = m << (23 - e);
        end
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    always @(negedge i_CLK) begin
        if (!i_RST_N) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            check("ready_rule", {31'b0, o_READY}, {31'b0, (~o_VALID | i_READY)});
            if (hold_v) begin
                check("stall_valid_held", {31'b0, o_VALID}, 32'd1);
                check("stall_res_stable", o_RES, hold_res);
            end
            if (o_VALID && i_READY) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %08h want none", o_RES);
                end else begin
                    check("result", o_RES, exp_q.pop_front());
                end
                out_val.push_back(o_RES);
                out_cyc.push_back(cyc);
            end
            hold_v   = o_VALID && !i_READY;
            hold_res = o_RES;
            if (i_VALID && o_READY) exp_q.push_back(model_i2f(i_INT));
        end
    end

    // ---------------- driver tasks ----------------
    // One cycle: drive after the rising edge, report acceptance mid-cycle.
    task automatic drive(input logic v, input logic [31:0] d, input logic r, output logic acc);
        i_VALID = v;
        i_INT   = d;
        i_READY = r;
        @(negedge i_CLK);
        acc = v & o_READY;
        @(posedge i_CLK);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        logic acc;
        int   n;
        n = 0;
        do begin
            drive(1'b1, d, 1'b1, acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got stuck want accept");
        end
        i_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) drive(1'b0, $urandom, 1'b1, acc);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 2000)) - 32'd1000;
            2:       v = 32'h0100_0000 + 32'($urandom_range(0, 16)) - 32'd8;
            3:       v = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
            default: begin
                case ($urandom_range(0, 3))
                    0:       v = 32'h8000_0000;
                    1:       v = 32'h7FFF_FFFF;
                    2:       v = 32'h0;
                    default: v = 32'hFFFF_FFFF;
                endcase
            end
        endcase
        return v;
    endfunction

    // ---------------- stimulus ----------------
    logic [31:0] vals[8];
    logic [31:0] lit_res[4];
    logic        acc;
    int          c0;
    int          idx;

    initial begin
        i_RST_N = 1'b0;
        i_VALID = 1'b0;
        i_INT   = '0;
        i_READY = 1'b1;
        repeat (3) @(posedge i_CLK);
        #1;
        check("reset_valid", {31'b0, o_VALID}, 32'd0);
        check("reset_res", o_RES, 32'h0);
        check("reset_ready", {31'b0, o_READY}, 32'd1);

        check("model_pin_1", model_i2f(32'd1), 32'h3F80_0000);
        check("model_pin_m1", model_i2f(32'hFFFF_FFFF), 32'hBF80_0000);
        check("model_pin_5", model_i2f(32'd5), 32'h40A0_0000);

        @(posedge i_CLK);
        #1;
        i_RST_N = 1'b1;
        idle(2);

        // back-to-back 1, -1, 0
        out_val.delete();
        out_cyc.delete();
        c0 = cyc;
        send(32'd1);
        send(32'hFFFF_FFFF);
        send(32'd0);
        idle(6);
        check("b2b_count", 32'(out_val.size()), 32'd3);
        if (out_val.size() == 3) begin
            check("b2b_res0", out_val[0], 32'h3F80_0000);
            check("b2b_res1", out_val[1], 32'hBF80_0000);
            check("b2b_res2", out_val[2], 32'h0000_0000);
            check("b2b_lat0", 32'(out_cyc[0] - c0), 32'd3);
            check("b2b_lat1", 32'(out_cyc[1] - c0), 32'd4);
            check("b2b_lat2", 32'(out_cyc[2] - c0), 32'd5);
        end

        // extremes and rounding boundary cases
`ifdef FP_I2F_RNE_EN
        lit_res = '{32'hCF00_0000, 32'h4F00_0000, 32'h4B80_0000, 32'h4B80_0002};
`else
        lit_res = '{32'hCF00_0000, 32'h4EFF_FFFF, 32'h4B80_0000, 32'h4B80_0001};
`endif
        out_val.delete();
        out_cyc.delete();
        send(32'h8000_0000);
        send(32'h7FFF_FFFF);
        send(32'd16777217);
        send(32'd16777219);
        idle(6);
        check("edge_count", 32'(out_val.size()), 32'd4);
        if (out_val.size() == 4) begin
            for (int i = 0; i < 4; i++) check("edge_res", out_val[i], lit_res[i]);
        end

        // stream of 8 with a 5-cycle downstream stall
        for (int i = 0; i < 8; i++) vals[i] = rand_operand();
        out_val.delete();
        out_cyc.delete();
        idx = 0;
        for (int c = 0; c < 60 && idx < 8; c++) begin
            drive(1'b1, vals[idx], !(c >= 4 && c < 9), acc);
            if (c >= 4 && c < 9) check("stall_ready_low", {31'b0, acc}, 32'd0);
            if (acc) idx++;
        end
        i_VALID = 1'b0;
        idle(8);
        check("stall_count", 32'(out_val.size()), 32'd8);
        if (out_val.size() == 8) begin
            for (int i = 0; i < 8; i++) check("stall_order", out_val[i], model_i2f(vals[i]));
        end

        // reset with three operands in flight
        send(32'd100);
        send(32'd200);
        send(32'd300);
        i_RST_N = 1'b0;
        #1;
        check("midrst_valid", {31'b0, o_VALID}, 32'd0);
        check("midrst_res", o_RES, 32'h0);
        check("midrst_ready", {31'b0, o_READY}, 32'd1);
        @(posedge i_CLK);
        #1;
        i_RST_N = 1'b1;
        out_val.delete();
        out_cyc.delete();
        c0 = cyc;
        send(32'd5);
        idle(6);
        check("postrst_count", 32'(out_val.size()), 32'd1);
        if (out_val.size() == 1) begin
            check("postrst_res", out_val[0], 32'h40A0_0000);
            check("postrst_lat", 32'(out_cyc[0] - c0), 32'd3);
        end

        // randomized traffic with random valid and downstream backpressure
        begin
            logic [31:0] d;
            logic        pend;
            pend = 1'b0;
            d    = '0;
            for (int c = 0; c < 600; c++) begin
                if (!pend) d = rand_operand();
                pend = ($urandom_range(0, 3) != 0);
                drive(pend, d, ($urandom_range(0, 3) != 0), acc);
                if (acc) pend = 1'b0;
            end
        end
        i_VALID = 1'b0;
        idle(10);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
